// File: rtl/cr_tlvp2_psr.sv
// TLV parser/splitter: steers each TLV of an AXI4-stream frame, whole, to the user or
// passthrough inbound FIFO by type; drains zero-length frames and flags framing errors.
module cr_tlvp2_psr #(
    parameter logic [31:0] USR_TYPE_MASK = 32'h0000_0006
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ib_tvalid,
    output logic        ib_tready,
    input  logic [63:0] ib_tdata,
    input  logic        ib_tlast,
    output logic        pt_ib_wr,
    output logic [63:0] pt_ib_data,
    output logic        pt_ib_sot,
    output logic        pt_ib_eot,
    output logic [4:0]  pt_ib_typ,
    input  logic        pt_ib_afull,
    output logic        usr_ib_wr,
    output logic [63:0] usr_ib_data,
    output logic        usr_ib_sot,
    output logic        usr_ib_eot,
    output logic [4:0]  usr_ib_typ,
    input  logic        usr_ib_afull,
    output logic        err_zero_len,
    output logic        err_len_mismatch
);

    typedef enum logic [1:0] {S_HDR, S_BODY, S_DRAIN} state_t;

    state_t      r_state;
    logic        r_sel;
    logic [4:0]  r_typ;
    logic [15:0] r_rem;

    logic        w_acc;
    logic [15:0] w_len;
    logic [4:0]  w_type;
    logic        w_hsel;
    logic        w_wr;
    logic        w_wsel;
    logic        w_sot;
    logic        w_eot;
    logic [4:0]  w_wtyp;
    logic        w_zl;
    logic        w_lm;

    assign w_len  = ib_tdata[31:16];
    assign w_type = ib_tdata[4:0];
    assign w_hsel = USR_TYPE_MASK[w_type];
    assign w_acc  = ib_tvalid & ib_tready;

    // In BODY only the owning FIFO can stall us; a header may go either way.
    always_comb begin
        ib_tready = 1'b0;
        case (r_state)
            S_HDR:   ib_tready = ~pt_ib_afull & ~usr_ib_afull;
            S_BODY:  ib_tready = r_sel ? ~usr_ib_afull : ~pt_ib_afull;
            S_DRAIN: ib_tready = 1'b1;
            default: ib_tready = 1'b0;
        endcase
        if (rst) ib_tready = 1'b0;
    end

    always_comb begin
        w_wr   = 1'b0;
        w_wsel = r_sel;
        w_sot  = 1'b0;
        w_eot  = 1'b0;
        w_wtyp = r_typ;
        w_zl   = 1'b0;
        w_lm   = 1'b0;
        if (w_acc) begin
            case (r_state)
                S_HDR: begin
                    if (w_len == 16'd0) begin
                        w_zl = 1'b1;
                    end else begin
                        w_wr   = 1'b1;
                        w_wsel = w_hsel;
                        w_sot  = 1'b1;
                        w_eot  = (w_len == 16'd1) | ib_tlast;
                        w_wtyp = w_type;
                        w_lm   = (w_len > 16'd1) & ib_tlast;
                    end
                end
                S_BODY: begin
                    w_wr  = 1'b1;
                    w_eot = (r_rem == 16'd1) | ib_tlast;
                    w_lm  = (r_rem != 16'd1) & ib_tlast;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_HDR;
            r_sel            <= 1'b0;
            r_typ            <= 5'd0;
            r_rem            <= 16'd0;
            pt_ib_wr         <= 1'b0;
            pt_ib_data       <= 64'd0;
            pt_ib_sot        <= 1'b0;
            pt_ib_eot        <= 1'b0;
            pt_ib_typ        <= 5'd0;
            usr_ib_wr        <= 1'b0;
            usr_ib_data      <= 64'd0;
            usr_ib_sot       <= 1'b0;
            usr_ib_eot       <= 1'b0;
            usr_ib_typ       <= 5'd0;
            err_zero_len     <= 1'b0;
            err_len_mismatch <= 1'b0;
        end else begin
            pt_ib_wr         <= w_wr & ~w_wsel;
            usr_ib_wr        <= w_wr & w_wsel;
            err_zero_len     <= w_zl;
            err_len_mismatch <= w_lm;
            // The idle path keeps its last payload so its outputs never toggle.
            if (w_wr & ~w_wsel) begin
                pt_ib_data <= ib_tdata;
                pt_ib_sot  <= w_sot;
                pt_ib_eot  <= w_eot;
                pt_ib_typ  <= w_wtyp;
            end
            if (w_wr & w_wsel) begin
                usr_ib_data <= ib_tdata;
                usr_ib_sot  <= w_sot;
                usr_ib_eot  <= w_eot;
                usr_ib_typ  <= w_wtyp;
            end
            if (w_acc) begin
                case (r_state)
                    S_HDR: begin
                        if (w_len == 16'd0) begin
                            r_state <= ib_tlast ? S_HDR : S_DRAIN;
                        end else begin
                            r_sel <= w_hsel;
                            r_typ <= w_type;
                            if ((w_len > 16'd1) && !ib_tlast) begin
                                r_rem   <= w_len - 16'd1;
                                r_state <= S_BODY;
                            end
                        end
                    end
                    S_BODY: begin
                        r_rem <= r_rem - 16'd1;
                        if ((r_rem == 16'd1) || ib_tlast) r_state <= S_HDR;
                    end
                    S_DRAIN: begin
                        if (ib_tlast) r_state <= S_HDR;
                    end
                    default: r_state <= S_HDR;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cr_tlvp2_psr.sv
// Scoreboard bench for cr_tlvp2_psr: expected FIFO writes are queued as words are
// accepted and matched, with latency and error flags, as the DUT writes them.
module tb_cr_tlvp2_psr;

    logic        clk = 1'b0;
    logic        rst;
    logic        ib_tvalid;
    logic        ib_tready;
    logic [63:0] ib_tdata;
    logic        ib_tlast;
    logic        pt_ib_wr, pt_ib_sot, pt_ib_eot, pt_ib_afull;
    logic [63:0] pt_ib_data;
    logic [4:0]  pt_ib_typ;
    logic        usr_ib_wr, usr_ib_sot, usr_ib_eot, usr_ib_afull;
    logic [63:0] usr_ib_data;
    logic [4:0]  usr_ib_typ;
    logic        err_zero_len, err_len_mismatch;

    cr_tlvp2_psr #(.USR_TYPE_MASK(32'h0000_0006)) dut (
        .clk(clk), .rst(rst),
        .ib_tvalid(ib_tvalid), .ib_tready(ib_tready), .ib_tdata(ib_tdata), .ib_tlast(ib_tlast),
        .pt_ib_wr(pt_ib_wr), .pt_ib_data(pt_ib_data), .pt_ib_sot(pt_ib_sot),
        .pt_ib_eot(pt_ib_eot), .pt_ib_typ(pt_ib_typ), .pt_ib_afull(pt_ib_afull),
        .usr_ib_wr(usr_ib_wr), .usr_ib_data(usr_ib_data), .usr_ib_sot(usr_ib_sot),
        .usr_ib_eot(usr_ib_eot), .usr_ib_typ(usr_ib_typ), .usr_ib_afull(usr_ib_afull),
        .err_zero_len(err_zero_len), .err_len_mismatch(err_len_mismatch)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d;
        logic        sot;
        logic        eot;
        logic [4:0]  typ;
        logic        lm;
        int          due;
    } exp_t;

    exp_t q_pt[$];
    exp_t q_usr[$];
    exp_t e_pt, e_usr;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int pt_cnt = 0, usr_cnt = 0, ez_cnt = 0, ez_cyc = -1;
    int last_due = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every write must match the head of its path's queue, one cycle after acceptance.
    always @(negedge clk) begin
        if (!rst) begin
            if (pt_ib_wr) begin
                pt_cnt++;
                n_chk++;
                if (q_pt.size() == 0) begin
                    $display("FAIL pt_unexpected_write data=%h sot=%b eot=%b typ=%0d", pt_ib_data, pt_ib_sot, pt_ib_eot, pt_ib_typ);
                end else begin
                    e_pt = q_pt.pop_front();
                    if (pt_ib_data !== e_pt.d || pt_ib_sot !== e_pt.sot || pt_ib_eot !== e_pt.eot ||
                        pt_ib_typ !== e_pt.typ || err_len_mismatch !== e_pt.lm || cyc !== e_pt.due)
                        $display("FAIL pt_write got d=%h sot=%b eot=%b typ=%0d lm=%b cyc=%0d want d=%h sot=%b eot=%b typ=%0d lm=%b cyc=%0d",
                                 pt_ib_data, pt_ib_sot, pt_ib_eot, pt_ib_typ, err_len_mismatch, cyc,
                                 e_pt.d, e_pt.sot, e_pt.eot, e_pt.typ, e_pt.lm, e_pt.due);
                    else n_pass++;
                end
            end
            if (usr_ib_wr) begin
                usr_cnt++;
                n_chk++;
                if (q_usr.size() == 0) begin
                    $display("FAIL usr_unexpected_write data=%h sot=%b eot=%b typ=%0d", usr_ib_data, usr_ib_sot, usr_ib_eot, usr_ib_typ);
                end else begin
                    e_usr = q_usr.pop_front();
                    if (usr_ib_data !== e_usr.d || usr_ib_sot !== e_usr.sot || usr_ib_eot !== e_usr.eot ||
                        usr_ib_typ !== e_usr.typ || err_len_mismatch !== e_usr.lm || cyc !== e_usr.due)
                        $display("FAIL usr_write got d=%h sot=%b eot=%b typ=%0d lm=%b cyc=%0d want d=%h sot=%b eot=%b typ=%0d lm=%b cyc=%0d",
                                 usr_ib_data, usr_ib_sot, usr_ib_eot, usr_ib_typ, err_len_mismatch, cyc,
                                 e_usr.d, e_usr.sot, e_usr.eot, e_usr.typ, e_usr.lm, e_usr.due);
                    else n_pass++;
                end
            end
            if (err_len_mismatch && !pt_ib_wr && !usr_ib_wr) begin
                n_chk++;
                $display("FAIL len_mismatch_without_write got=1 want=0 cyc=%0d", cyc);
            end
            if (err_zero_len) begin
                ez_cnt++;
                ez_cyc = cyc;
            end
        end
    end

    function automatic logic [63:0] hdr(input logic [4:0] t, input logic [15:0] l);
        logic [31:0] up;
        up = $urandom();
        return {up, l, 11'h5A5, t};
    endfunction

    // path: 0 = no write expected, 1 = passthrough, 2 = user. Called at a negedge.
    task automatic send(input logic [63:0] d, input logic l, input int path,
                        input logic sot, input logic eot, input logic [4:0] typ,
                        input logic lm, output int waited);
        exp_t e;
        waited = 0;
        #1;
        ib_tvalid = 1'b1;
        ib_tdata  = d;
        ib_tlast  = l;
        while (!ib_tready && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!ib_tready) begin
            n_chk++;
            $display("FAIL send_timeout tready=%b want=1 data=%h", ib_tready, d);
            ib_tvalid = 1'b0;
        end else begin
            last_due = cyc + 1;
            e.d = d; e.sot = sot; e.eot = eot; e.typ = typ; e.lm = lm; e.due = last_due;
            if (path == 1) q_pt.push_back(e);
            if (path == 2) q_usr.push_back(e);
            @(negedge clk);
            ib_tvalid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if (ib_tready !== 1'b0 || pt_ib_wr !== 1'b0 || usr_ib_wr !== 1'b0 || pt_ib_data !== 64'd0 ||
            usr_ib_data !== 64'd0 || err_zero_len !== 1'b0 || err_len_mismatch !== 1'b0)
            $display("FAIL reset_state tready=%b pt_wr=%b usr_wr=%b pt_d=%h usr_d=%h ez=%b lm=%b want all 0",
                     ib_tready, pt_ib_wr, usr_ib_wr, pt_ib_data, usr_ib_data, err_zero_len, err_len_mismatch);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_routing();
        int w;
        int ez0;
        logic [63:0] d;
        ez0 = ez_cnt;
        send(hdr(5'd1, 16'd3), 1'b0, 2, 1'b1, 1'b0, 5'd1, 1'b0, w);
        d = {$urandom(), $urandom()}; send(d, 1'b0, 2, 1'b0, 1'b0, 5'd1, 1'b0, w);
        d = {$urandom(), $urandom()}; send(d, 1'b0, 2, 1'b0, 1'b1, 5'd1, 1'b0, w);
        send(hdr(5'd5, 16'd2), 1'b0, 1, 1'b1, 1'b0, 5'd5, 1'b0, w);
        d = {$urandom(), $urandom()}; send(d, 1'b1, 1, 1'b0, 1'b1, 5'd5, 1'b0, w);
        repeat (2) @(negedge clk);
        n_chk++;
        if (ez_cnt !== ez0) $display("FAIL routing_no_zero_len got=%0d want=%0d", ez_cnt, ez0);
        else n_pass++;
    endtask

    task automatic test_single_word();
        int w;
        send(hdr(5'd2, 16'd1), 1'b1, 2, 1'b1, 1'b1, 5'd2, 1'b0, w);
        // Following word must be parsed as a new header.
        send(hdr(5'd6, 16'd1), 1'b1, 1, 1'b1, 1'b1, 5'd6, 1'b0, w);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_backpressure();
        int w;
        int snap;
        logic [63:0] d;
        send(hdr(5'd1, 16'd4), 1'b0, 2, 1'b1, 1'b0, 5'd1, 1'b0, w);
        d = {$urandom(), $urandom()}; send(d, 1'b0, 2, 1'b0, 1'b0, 5'd1, 1'b0, w);
        usr_ib_afull = 1'b1;
        ib_tvalid = 1'b1;
        ib_tdata = {$urandom(), $urandom()};
        ib_tlast = 1'b0;
        #1;
        snap = usr_cnt;
        repeat (4) begin
            @(negedge clk);
            n_chk++;
            if (ib_tready !== 1'b0) $display("FAIL bp_tready got=%b want=0", ib_tready);
            else n_pass++;
        end
        ib_tvalid = 1'b0;
        usr_ib_afull = 1'b0;
        #1;
        n_chk++;
        if (usr_cnt !== snap) $display("FAIL bp_no_writes got=%0d want=%0d", usr_cnt, snap);
        else n_pass++;
        @(negedge clk);
        send(ib_tdata, 1'b0, 2, 1'b0, 1'b0, 5'd1, 1'b0, w);
        d = {$urandom(), $urandom()}; send(d, 1'b1, 2, 1'b0, 1'b1, 5'd1, 1'b0, w);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_early_tlast();
        int w;
        logic [63:0] d;
        send(hdr(5'd3, 16'd5), 1'b0, 1, 1'b1, 1'b0, 5'd3, 1'b0, w);
        d = {$urandom(), $urandom()}; send(d, 1'b0, 1, 1'b0, 1'b0, 5'd3, 1'b0, w);
        d = {$urandom(), $urandom()}; send(d, 1'b1, 1, 1'b0, 1'b1, 5'd3, 1'b1, w);
        send(hdr(5'd2, 16'd1), 1'b1, 2, 1'b1, 1'b1, 5'd2, 1'b0, w);
        // Header claiming len>1 but carrying tlast itself.
        send(hdr(5'd1, 16'd7), 1'b1, 2, 1'b1, 1'b1, 5'd1, 1'b1, w);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_zero_len();
        int w;
        int ez0, p0, u0, hdue, wsum;
        logic [63:0] d;
        ez0 = ez_cnt;
        send(hdr(5'd1, 16'd0), 1'b0, 0, 1'b0, 1'b0, 5'd0, 1'b0, w);
        hdue = last_due;
        p0 = pt_cnt; u0 = usr_cnt;
        // DRAIN must ignore full FIFOs.
        pt_ib_afull = 1'b1;
        usr_ib_afull = 1'b1;
        wsum = 0;
        d = {$urandom(), $urandom()}; send(d, 1'b0, 0, 1'b0, 1'b0, 5'd0, 1'b0, w); wsum += w;
        d = {$urandom(), $urandom()}; send(d, 1'b0, 0, 1'b0, 1'b0, 5'd0, 1'b0, w); wsum += w;
        d = {$urandom(), $urandom()}; send(d, 1'b1, 0, 1'b0, 1'b0, 5'd0, 1'b0, w); wsum += w;
        n_chk++;
        if (wsum !== 0) $display("FAIL zl_tready_stalls got=%0d want=0", wsum);
        else n_pass++;
        pt_ib_afull = 1'b0;
        usr_ib_afull = 1'b0;
        @(negedge clk);
        n_chk++;
        if (pt_cnt !== p0 || usr_cnt !== u0)
            $display("FAIL zl_no_writes got pt=%0d usr=%0d want pt=%0d usr=%0d", pt_cnt, usr_cnt, p0, u0);
        else n_pass++;
        n_chk++;
        if (ez_cnt !== ez0 + 1 || ez_cyc !== hdue)
            $display("FAIL zl_pulse got cnt=%0d cyc=%0d want cnt=%0d cyc=%0d", ez_cnt - ez0, ez_cyc, 1, hdue);
        else n_pass++;
        send(hdr(5'd5, 16'd2), 1'b0, 1, 1'b1, 1'b0, 5'd5, 1'b0, w);
        d = {$urandom(), $urandom()}; send(d, 1'b1, 1, 1'b0, 1'b1, 5'd5, 1'b0, w);
        // len 0 with tlast: error, but no drain.
        send(hdr(5'd2, 16'd0), 1'b1, 0, 1'b0, 1'b0, 5'd0, 1'b0, w);
        send(hdr(5'd2, 16'd1), 1'b1, 2, 1'b1, 1'b1, 5'd2, 1'b0, w);
        repeat (2) @(negedge clk);
        n_chk++;
        if (ez_cnt !== ez0 + 2) $display("FAIL zl_tlast_pulse got=%0d want=%0d", ez_cnt - ez0, 2);
        else n_pass++;
    endtask

    task automatic test_reset_mid_tlv();
        int w;
        logic [63:0] d;
        send(hdr(5'd1, 16'd6), 1'b0, 2, 1'b1, 1'b0, 5'd1, 1'b0, w);
        d = {$urandom(), $urandom()}; send(d, 1'b0, 2, 1'b0, 1'b0, 5'd1, 1'b0, w);
        #1;
        rst = 1'b1;
        #1;
        n_chk++;
        if (ib_tready !== 1'b0) $display("FAIL rst_tready got=%b want=0", ib_tready);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (usr_ib_wr !== 1'b0 || usr_ib_data !== 64'd0 || usr_ib_sot !== 1'b0 || usr_ib_eot !== 1'b0 ||
            usr_ib_typ !== 5'd0 || pt_ib_wr !== 1'b0 || pt_ib_data !== 64'd0 || ib_tready !== 1'b0)
            $display("FAIL rst_outputs usr_wr=%b usr_d=%h sot=%b eot=%b typ=%0d pt_wr=%b pt_d=%h tready=%b want all 0",
                     usr_ib_wr, usr_ib_data, usr_ib_sot, usr_ib_eot, usr_ib_typ, pt_ib_wr, pt_ib_data, ib_tready);
        else n_pass++;
        rst = 1'b0;
        send(hdr(5'd5, 16'd1), 1'b1, 1, 1'b1, 1'b1, 5'd5, 1'b0, w);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        ib_tvalid = 1'b0;
        ib_tdata = 64'd0;
        ib_tlast = 1'b0;
        pt_ib_afull = 1'b0;
        usr_ib_afull = 1'b0;
        test_reset();
        test_routing();
        test_single_word();
        test_backpressure();
        test_early_tlast();
        test_zero_len();
        test_reset_mid_tlv();
        repeat (3) @(negedge clk);
        n_chk++;
        if (q_pt.size() != 0 || q_usr.size() != 0)
            $display("FAIL scoreboard_drained got pt=%0d usr=%0d want 0", q_pt.size(), q_usr.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
